// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// wait-counter width and the store byte-mask helper.
package dmem_responder_pkg;

  localparam int DMEM_WCNT_WIDTH = 4;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE   = 2'd0,
    DMEM_ST_WAIT   = 2'd1,
    DMEM_ST_ACCESS = 2'd2,
    DMEM_ST_RESP   = 2'd3
  } dmem_state_e;

  // A rejected (misaligned) store or any load must never touch the array.
  function automatic logic [3:0] dmemStoreMask(input logic we, input logic misalign,
                                               input logic [3:0] be);
    return (we && !misalign) ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Synchronous DEPTH_WORDS x 32 word array with per-byte write enables and a
// registered read port; contents are deliberately left unreset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time, fixed wait
// states, then a held response. Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_WCNT_WIDTH-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? DMEM_WCNT_WIDTH'(WAIT_CYCLES - 1) : '0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
    $error("dmem_responder: WAIT_CYCLES must be within 0..15");
  end

  dmem_state_e                state_q, state_d;
  logic [DMEM_WCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [3:0]                 be_q, be_d;
  logic                       misalign_q, misalign_d;
  logic                       rspValid_q, rspValid_d;
  logic [31:0]                rspRdata_q, rspRdata_d;
  logic                       rspErr_q, rspErr_d;

  logic [IDX_W-1:0]           reqIdx;
  logic                       reqMisalign;
  logic                       unusedAddrBits;
  logic [IDX_W-1:0]           ramAddr;
  logic [3:0]                 ramBe;
  logic                       ramRe;
  logic [31:0]                ramRdata;

  // Upper address bits alias onto the array; low bits only matter for the check.
  assign reqIdx         = req_addr_i[IDX_W+1:2];
  assign unusedAddrBits = ^{req_addr_i[ADDR_WIDTH-1:IDX_W+2], req_addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign reqMisalign = |req_addr_i[1:0];
`else
  assign reqMisalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DMEM_ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      misalign_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // The array read is launched on the edge entering ACCESS so its registered
  // output is ready to be captured into the response on the ACCESS exit edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    misalign_d = misalign_q;
    rspValid_d = rspValid_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    ramBe      = 4'b0000;
    ramAddr    = idx_q;

    case (state_q)
      DMEM_ST_IDLE: begin
        ramAddr = reqIdx;
        if (req_valid_i) begin
          we_d       = req_we_i;
          idx_d      = reqIdx;
          wdata_d    = req_wdata_i;
          be_d       = req_be_i;
          misalign_d = reqMisalign;
          if (WAIT_CYCLES > 0) begin
            state_d = DMEM_ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = DMEM_ST_ACCESS;
          end
        end
      end
      DMEM_ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMEM_ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMEM_ST_ACCESS: begin
        ramBe      = dmemStoreMask(we_q, misalign_q, be_q);
        rspValid_d = 1'b1;
        rspRdata_d = (we_q || misalign_q) ? 32'h0 : ramRdata;
        rspErr_d   = misalign_q;
        state_d    = DMEM_ST_RESP;
      end
      DMEM_ST_RESP: begin
        if (rsp_ready_i) begin
          rspValid_d = 1'b0;
          state_d    = DMEM_ST_IDLE;
        end
      end
      default: begin
        state_d = DMEM_ST_IDLE;
      end
    endcase

    ramRe = (state_d == DMEM_ST_ACCESS);
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) uArray (
    .clk     (clk),
    .addr_i  (ramAddr),
    .be_i    (ramBe),
    .wdata_i (wdata_q),
    .re_i    (ramRe),
    .rdata_o (ramRdata)
  );

  assign req_ready_o = (state_q == DMEM_ST_IDLE);
  assign rsp_valid_o = rspValid_q;
  assign rsp_rdata_o = rspRdata_q;
  assign rsp_err_o   = rspErr_q;

endmodule
